// File: rtl/board_disp_arbiter_pkg.sv
// Shared types, constants and width helper for the board display arbiter.
package board_disp_arbiter_pkg;

  localparam int unsigned OWNER_W      = 2;
  localparam int unsigned EN_W         = 8;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned DOT_W        = 8;
  localparam int unsigned LED_W        = 16;
  localparam int unsigned RETRY_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } disp_state_e;

  typedef struct packed {
    logic [EN_W-1:0]   en;
    logic [DATA_W-1:0] data;
    logic [DOT_W-1:0]  dot;
    logic [LED_W-1:0]  led;
  } disp_fields_t;

  // Bits needed to hold values 0..max_value.
  function automatic int unsigned get_width(input int unsigned max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/disp_prio_arb.sv
// Fixed-priority arbiter (index 0 highest) with a saturating minimum-hold counter.
module disp_prio_arb
  import board_disp_arbiter_pkg::*;
#(
  parameter int unsigned CLIENTS     = 4,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CLIENTS-1:0] i_req,
  output logic [CLIENTS-1:0] o_grant,
  output logic [OWNER_W-1:0] o_owner
);

  localparam int unsigned HOLD_W = get_width(HOLD_CYCLES);

  logic [CLIENTS-1:0] r_grant;
  logic [OWNER_W-1:0] r_owner;
  logic [HOLD_W-1:0]  r_hold;
  logic [CLIENTS-1:0] w_top_grant;
  logic [OWNER_W-1:0] w_top_idx;
  logic               w_higher;
  logic               w_any;
  logic               w_owned;
  logic               w_keep;
  logic               w_hold_done;

  // Highest-priority requester, and whether it outranks the current owner.
  always_comb begin
    w_top_grant = '0;
    w_top_idx   = '0;
    w_higher    = 1'b0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_top_grant    = '0;
        w_top_grant[i] = 1'b1;
        w_top_idx      = OWNER_W'(i);
        if (OWNER_W'(i) < r_owner) begin
          w_higher = 1'b1;
        end
      end
    end
  end

  assign w_any       = |i_req;
  assign w_owned     = |r_grant;
  assign w_keep      = |(r_grant & i_req);
  assign w_hold_done = (r_hold == HOLD_W'(HOLD_CYCLES));

  // Grant, release (one idle cycle before re-arbitration) and hold-gated preemption.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_owner <= '0;
      r_hold  <= '0;
    end else if (!w_owned) begin
      if (w_any) begin
        r_grant <= w_top_grant;
        r_owner <= w_top_idx;
      end
      r_hold <= '0;
    end else if (!w_keep) begin
      r_grant <= '0;
      r_owner <= '0;
      r_hold  <= '0;
    end else if (w_higher && w_hold_done) begin
      r_grant <= w_top_grant;
      r_owner <= w_top_idx;
      r_hold  <= '0;
    end else if (!w_hold_done) begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  assign o_grant = r_grant;
  assign o_owner = r_owner;

endmodule

// File: rtl/board_disp_arbiter.sv
// Shares the LED bar and 7-segment tubes between requesters and sequences the serial display driver.
module board_disp_arbiter
  import board_disp_arbiter_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100,
  parameter int unsigned CLIENTS    = 4,
  parameter int unsigned HOLD_MS    = 500,
  parameter int unsigned REFRESH_MS = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CLIENTS-1:0]        i_req,
  output logic [CLIENTS-1:0]        o_grant,
  output logic [OWNER_W-1:0]        o_owner,
  input  logic [EN_W*CLIENTS-1:0]   i_cl_en,
  input  logic [DATA_W*CLIENTS-1:0] i_cl_data,
  input  logic [DOT_W*CLIENTS-1:0]  i_cl_dot,
  input  logic [LED_W*CLIENTS-1:0]  i_cl_led,
  output logic [EN_W-1:0]           o_disp_en,
  output logic [DATA_W-1:0]         o_disp_data,
  output logic [DOT_W-1:0]          o_disp_dot,
  output logic [LED_W-1:0]          o_disp_led,
  output logic                      o_disp_start,
  input  logic                      i_disp_busy
);

  localparam int unsigned HOLD_CYCLES    = CLK_FREQ * HOLD_MS * 1000;
  localparam int unsigned REFRESH_CYCLES = CLK_FREQ * REFRESH_MS * 1000;
  localparam int unsigned REF_W          = get_width(REFRESH_CYCLES - 1);
  localparam int unsigned WAIT_W         = get_width(RETRY_CYCLES - 1);

  disp_state_e        r_state;
  disp_state_e        w_state_nxt;
  disp_fields_t       r_disp;
  disp_fields_t       w_src;
  logic               r_disp_start;
  logic               r_pending;
  logic [REF_W-1:0]   r_refresh;
  logic [WAIT_W-1:0]  r_wait;
  logic [CLIENTS-1:0] r_grant_d;
  logic [CLIENTS-1:0] w_grant;
  logic [OWNER_W-1:0] w_owner;
  logic               w_diff;
  logic               w_owner_chg;
  logic               w_wrap;
  logic               w_retry;
  logic               w_set;
  logic               w_pend;

  disp_prio_arb #(
    .CLIENTS     (CLIENTS),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .o_grant (w_grant),
    .o_owner (w_owner)
  );

  // Owner's display fields; blank when nobody owns the display.
  always_comb begin
    w_src = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (w_grant[i]) begin
        w_src.en   = i_cl_en[EN_W*i +: EN_W];
        w_src.data = i_cl_data[DATA_W*i +: DATA_W];
        w_src.dot  = i_cl_dot[DOT_W*i +: DOT_W];
        w_src.led  = i_cl_led[LED_W*i +: LED_W];
      end
    end
  end

  // Update triggers; a content diff seen during LOAD is already resolved by that capture.
  assign w_diff      = (w_src != r_disp);
  assign w_owner_chg = (w_grant != r_grant_d);
  assign w_wrap      = (r_refresh == REF_W'(REFRESH_CYCLES - 1));
  assign w_retry     = (r_state == ST_WAIT_HI) && !i_disp_busy &&
                       (r_wait == WAIT_W'(RETRY_CYCLES - 1));
  assign w_set       = w_owner_chg | w_wrap | w_retry | (w_diff & (r_state != ST_LOAD));
  assign w_pend      = r_pending | w_set;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pend && !i_disp_busy) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD:  w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (i_disp_busy) begin
          w_state_nxt = ST_WAIT_LO;
        end else if (w_retry) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        if (!i_disp_busy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Display snapshot, start pulse and pending flag (a set in the LOAD cycle wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp       <= '0;
      r_disp_start <= 1'b0;
      r_pending    <= 1'b1;
      r_grant_d    <= '0;
    end else begin
      r_disp_start <= (r_state == ST_START);
      r_grant_d    <= w_grant;
      if (r_state == ST_LOAD) begin
        r_disp    <= w_src;
        r_pending <= w_set;
      end else begin
        r_pending <= w_pend;
      end
    end
  end

  // Free-running refresh counter and busy-rise timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_wait    <= '0;
    end else begin
      r_refresh <= w_wrap ? '0 : r_refresh + REF_W'(1);
      r_wait    <= (r_state == ST_WAIT_HI) ? r_wait + WAIT_W'(1) : '0;
    end
  end

  assign o_grant      = w_grant;
  assign o_owner      = w_owner;
  assign o_disp_en    = r_disp.en;
  assign o_disp_data  = r_disp.data;
  assign o_disp_dot   = r_disp.dot;
  assign o_disp_led   = r_disp.led;
  assign o_disp_start = r_disp_start;

endmodule

// File: tb/tb_board_disp_arbiter.sv
// Directed bench for board_disp_arbiter with 1000-cycle hold/refresh and a simple driver model.
module tb_board_disp_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic [31:0]  cl_en;
  logic [127:0] cl_data;
  logic [31:0]  cl_dot;
  logic [63:0]  cl_led;
  logic [7:0]   disp_en;
  logic [31:0]  disp_data;
  logic [7:0]   disp_dot;
  logic [15:0]  disp_led;
  logic         disp_start;
  logic         busy = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int n_starts = 0;
  int drv_cnt  = 0;
  bit drv_dead = 1'b0;
  int g_cyc    = 0;

  always #5 clk = ~clk;

  board_disp_arbiter #(
    .CLK_FREQ   (1),
    .CLIENTS    (4),
    .HOLD_MS    (1),
    .REFRESH_MS (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (req),
    .o_grant      (grant),
    .o_owner      (owner),
    .i_cl_en      (cl_en),
    .i_cl_data    (cl_data),
    .i_cl_dot     (cl_dot),
    .i_cl_led     (cl_led),
    .o_disp_en    (disp_en),
    .o_disp_data  (disp_data),
    .o_disp_dot   (disp_dot),
    .o_disp_led   (disp_led),
    .o_disp_start (disp_start),
    .i_disp_busy  (busy)
  );

  // Cycles since reset release (refresh counter mirror).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Start pulse counter.
  always @(negedge clk) begin
    if (disp_start === 1'b1) n_starts++;
  end

  // Driver model: busy rises 2 cycles after start and stays high 20 cycles.
  always @(negedge clk) begin
    if (rst) begin
      busy    = 1'b0;
      drv_cnt = 0;
    end else if (drv_cnt == 0) begin
      if (disp_start === 1'b1 && !drv_dead) drv_cnt = 1;
    end else begin
      drv_cnt = drv_cnt + 1;
      if (drv_cnt == 2) busy = 1'b1;
      if (drv_cnt == 22) begin
        busy    = 1'b0;
        drv_cnt = 0;
      end
    end
  end

  task automatic align(input int phase);
    int guard = 0;
    while ((cyc % 1000) != phase && guard < 1100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1100) begin
      checks++; errors++;
      $display("FAIL align_timeout: cyc %0d never reached phase %0d", cyc, phase);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; cl_en = '0; cl_data = '0; cl_dot = '0; cl_led = '0; drv_dead = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if ({disp_en, disp_data, disp_dot, disp_led} !== 64'h0) begin
      errors++; $display("FAIL reset_disp: got %h expected 0", {disp_en, disp_data, disp_dot, disp_led}); end
    checks++; if (disp_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", disp_start); end
    rst = 1'b0;
  endtask

  task automatic test_boot_refresh();
    int st[$];
    int guard = 0;
    while (cyc < 2500 && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (disp_start === 1'b1) begin
        st.push_back(cyc);
        if (st.size() == 1) begin
          checks++; if ({disp_en, disp_data, disp_dot, disp_led} !== 64'h0) begin
            errors++; $display("FAIL boot_blank: got %h expected 0", {disp_en, disp_data, disp_dot, disp_led}); end
        end
      end
    end
    checks++; if (st.size() != 3) begin errors++; $display("FAIL boot_start_count: got %0d expected 3", st.size()); end
    checks++; if (st.size() < 1 || st[0] != 3) begin errors++; $display("FAIL boot_first_start: got cycle %0d expected 3", (st.size() > 0) ? st[0] : -1); end
    checks++; if (st.size() < 2 || st[1] != 1002) begin errors++; $display("FAIL refresh_start: got cycle %0d expected 1002", (st.size() > 1) ? st[1] : -1); end
    checks++; if (st.size() < 3 || st[2] - st[1] != 1000) begin errors++; $display("FAIL refresh_period: got %0d expected 1000", (st.size() > 2) ? st[2] - st[1] : -1); end
  endtask

  task automatic test_grant_latency();
    int n0;
    align(100);
    cl_data[95:64] = 32'h1234_5678;
    cl_en[23:16]   = 8'h0F;
    req            = 4'b0100;
    n0 = n_starts;
    @(negedge clk);
    g_cyc = cyc;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL grant_next: got %b expected 0100", grant); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL owner_next: got %0d expected 2", owner); end
    @(negedge clk);
    checks++; if (disp_data !== 32'h0) begin errors++; $display("FAIL data_early: got %h expected 0", disp_data); end
    @(negedge clk);
    checks++; if (disp_data !== 32'h1234_5678) begin errors++; $display("FAIL data_latency: got %h expected 12345678", disp_data); end
    checks++; if (disp_en !== 8'h0F) begin errors++; $display("FAIL en_latency: got %h expected 0f", disp_en); end
    checks++; if (disp_start !== 1'b0) begin errors++; $display("FAIL start_early: got %b expected 0", disp_start); end
    @(negedge clk);
    checks++; if (disp_start !== 1'b1) begin errors++; $display("FAIL start_latency: got %b expected 1", disp_start); end
    repeat (40) @(negedge clk);
    checks++; if (n_starts - n0 != 1) begin errors++; $display("FAIL grant_single_start: got %0d expected 1", n_starts - n0); end
  endtask

  task automatic test_preempt();
    int guard = 0;
    int p_cyc;
    cl_data[31:0] = 32'hCAFE_0000;
    while (cyc < g_cyc + 100 && guard < 200) begin @(negedge clk); guard++; end
    req = 4'b1101;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL preempt_early: got %b expected 0100", grant); end
    guard = 0;
    while (grant === 4'b0100 && guard < 1500) begin @(negedge clk); guard++; end
    p_cyc = cyc;
    checks++; if (grant !== 4'b0001 || owner !== 2'd0) begin errors++; $display("FAIL preempt_grant: got %b/%0d expected 0001/0", grant, owner); end
    checks++; if (p_cyc != g_cyc + 1001) begin errors++; $display("FAIL preempt_time: got %0d expected %0d", p_cyc - g_cyc, 1001); end
    repeat (2) @(negedge clk);
    checks++; if (disp_data !== 32'hCAFE_0000) begin errors++; $display("FAIL preempt_data: got %h expected cafe0000", disp_data); end
    @(negedge clk);
    checks++; if (disp_start !== 1'b1) begin errors++; $display("FAIL preempt_start: got %b expected 1", disp_start); end
  endtask

  task automatic test_coalesce();
    int n0;
    int guard = 0;
    req = 4'b0010;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL release_grant: got %b expected 0000", grant); end
    @(negedge clk);
    checks++; if (grant !== 4'b0010 || owner !== 2'd1) begin errors++; $display("FAIL rearb_grant: got %b/%0d expected 0010/1", grant, owner); end
    repeat (40) @(negedge clk);
    align(300);
    n0 = n_starts;
    cl_led[31:16] = 16'h0001;
    while (busy !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("FAIL coalesce_busy_timeout: busy %b expected 1", busy); end
    checks++; if (disp_led !== 16'h0001) begin errors++; $display("FAIL coalesce_first: got %h expected 0001", disp_led); end
    cl_led[31:16] = 16'h0002; repeat (3) @(negedge clk);
    cl_led[31:16] = 16'h0003; repeat (3) @(negedge clk);
    cl_led[31:16] = 16'hBEEF; repeat (3) @(negedge clk);
    checks++; if (disp_led !== 16'h0001) begin errors++; $display("FAIL coalesce_stable: got %h expected 0001", disp_led); end
    repeat (60) @(negedge clk);
    checks++; if (n_starts - n0 != 2) begin errors++; $display("FAIL coalesce_starts: got %0d expected 2", n_starts - n0); end
    checks++; if (disp_led !== 16'hBEEF) begin errors++; $display("FAIL coalesce_last: got %h expected beef", disp_led); end
  endtask

  task automatic test_no_busy();
    int st[$];
    align(500);
    drv_dead = 1'b1;
    cl_dot[15:8] = 8'h5A;
    repeat (30) begin
      @(negedge clk);
      if (disp_start === 1'b1) st.push_back(cyc);
    end
    checks++; if (st.size() < 3) begin errors++; $display("FAIL retry_count: got %0d expected >=3", st.size()); end
    checks++; if (st.size() < 2 || st[1] - st[0] != 7) begin errors++; $display("FAIL retry_gap: got %0d expected 7", (st.size() > 1) ? st[1] - st[0] : -1); end
    checks++; if (disp_dot !== 8'h5A) begin errors++; $display("FAIL retry_dot: got %h expected 5a", disp_dot); end
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL retry_grant: got %b expected 0010", grant); end
    drv_dead = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL retry_grant_after: got %b expected 0010", grant); end
  endtask

  task automatic test_reset_mid();
    int st[$];
    int guard = 0;
    align(700);
    cl_data[63:32] = 32'h0000_00AA;
    while (busy !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("FAIL midrst_busy_timeout: busy %b expected 1", busy); end
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    checks++; if (grant !== 4'b0000 || owner !== 2'd0) begin errors++; $display("FAIL midrst_grant: got %b/%0d expected 0000/0", grant, owner); end
    checks++; if ({disp_en, disp_data, disp_dot, disp_led} !== 64'h0) begin
      errors++; $display("FAIL midrst_disp: got %h expected 0", {disp_en, disp_data, disp_dot, disp_led}); end
    checks++; if (disp_start !== 1'b0) begin errors++; $display("FAIL midrst_start: got %b expected 0", disp_start); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (disp_start === 1'b1) begin
        st.push_back(cyc);
        checks++; if ({disp_en, disp_data, disp_dot, disp_led} !== 64'h0) begin
          errors++; $display("FAIL midrst_blank: got %h expected 0", {disp_en, disp_data, disp_dot, disp_led}); end
      end
    end
    checks++; if (st.size() != 1 || st[0] != 3) begin errors++; $display("FAIL midrst_refresh: got %0d starts, first %0d expected 1 at 3", st.size(), (st.size() > 0) ? st[0] : -1); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL midrst_idle_grant: got %b expected 0000", grant); end
  endtask

  initial begin
    test_reset();
    test_boot_refresh();
    test_grant_latency();
    test_preempt();
    test_coalesce();
    test_no_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
